// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM controller,
// the cell array top and the bench.
package cam_pkg;

  localparam int CAM_WIDTH = 8;
  localparam int CAM_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_SEARCH = 2'd1,
    OP_READ   = 2'd2,
    OP_INVAL  = 2'd3
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_READ   = 3'd4,
    ST_RESP   = 3'd5
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder for the word-match vector.
// Combinational; idx is 0 when nothing is set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic             hit,
  output logic [AW-1:0]    idx
);

  always_comb begin
    hit = |vec;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = AW'(i);
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Request-side sequencer for a CAM cell array: write, search,
// read and invalidate over valid/ready request/response channels.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH = CAM_WIDTH,
  parameter int DEPTH = CAM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [AW-1:0]          req_addr_i,
  input  logic [WIDTH-1:0]       req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [AW-1:0]          rsp_idx_o,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic [DEPTH-1:0]       cell_we_o,
  output logic [WIDTH-1:0]       cell_data_o,
  output logic                   cell_se_o,
  output logic [WIDTH-1:0]       cell_search_o,
  input  logic [DEPTH*WIDTH-1:0] cell_match_i,
  input  logic [DEPTH*WIDTH-1:0] cell_data_i
);

  cam_state_e       state;
  cam_op_e          op;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic             hit_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] rdata_q;
  logic [DEPTH-1:0] word_match;
  logic             enc_hit;
  logic [AW-1:0]    enc_idx;
  logic [WIDTH-1:0] rd_word;

  assign op = cam_op_e'(req_op_i);

  always_comb begin
    word_match = '0;
    for (int w = 0; w < DEPTH; w++) begin
      word_match[w] = (&cell_match_i[w*WIDTH +: WIDTH]) & valid[w];
    end
  end

  cam_prio_enc #(
    .DEPTH (DEPTH)
  ) u_enc (
    .vec (word_match),
    .hit (enc_hit),
    .idx (enc_idx)
  );

  assign rd_word = cell_data_i[int'(addr_q)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      valid   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            data_q  <= req_data_i;
            hit_q   <= 1'b1;
            idx_q   <= req_addr_i;
            rdata_q <= '0;
            unique case (op)
              OP_WRITE:  state <= ST_WRITE;
              OP_SEARCH: state <= ST_SEARCH;
              OP_READ:   state <= ST_READ;
              OP_INVAL: begin
                valid[req_addr_i] <= 1'b0;
                state <= ST_RESP;
              end
            endcase
          end
        end
        ST_WRITE: begin
          valid[addr_q] <= 1'b1;
          state <= ST_RESP;
        end
        ST_SEARCH: state <= ST_WAIT;
        ST_WAIT: begin
          hit_q <= enc_hit;
          idx_q <= enc_idx;
          state <= ST_RESP;
        end
        ST_READ: begin
          rdata_q <= rd_word;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated with reset so ready only rises once reset is released
  assign req_ready_o = reset & (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_hit_o   = hit_q;
  assign rsp_idx_o   = idx_q;
  assign rsp_data_o  = rdata_q;

  always_comb begin
    cell_we_o = '0;
    if (state == ST_WRITE) cell_we_o[addr_q] = 1'b1;
  end

  assign cell_data_o   = (state == ST_WRITE) ? data_q : '0;
  assign cell_se_o     = (state == ST_SEARCH);
  assign cell_search_o = (state == ST_SEARCH) ? data_q : '0;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural cell array model.
// WIDTH=8, DEPTH=4.
module tb_cam_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [1:0]  req_addr_i;
  logic [7:0]  req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_hit_o;
  logic [1:0]  rsp_idx_o;
  logic [7:0]  rsp_data_o;
  logic [3:0]  cell_we_o;
  logic [7:0]  cell_data_o;
  logic        cell_se_o;
  logic [7:0]  cell_search_o;
  logic [31:0] cell_match_i;
  logic [31:0] cell_data_i;

  int vecs;
  int errs;
  int hs_cnt;

  logic [7:0]  mem [4];
  logic [31:0] match_q;

  cam_ctrl #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_hit_o     (rsp_hit_o),
    .rsp_idx_o     (rsp_idx_o),
    .rsp_data_o    (rsp_data_o),
    .cell_we_o     (cell_we_o),
    .cell_data_o   (cell_data_o),
    .cell_se_o     (cell_se_o),
    .cell_search_o (cell_search_o),
    .cell_match_i  (cell_match_i),
    .cell_data_i   (cell_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array: contents survive reset, match is registered on se
  initial begin
    for (int w = 0; w < 4; w++) mem[w] = 8'h00;
    match_q = '0;
  end

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (cell_we_o[w]) mem[w] <= cell_data_o;
      if (cell_se_o) match_q[w*8 +: 8] <= ~(mem[w] ^ cell_search_o);
    end
  end

  assign cell_match_i = match_q;
  assign cell_data_i  = {mem[3], mem[2], mem[1], mem[0]};

  always @(posedge clk) begin
    if (rsp_valid_o && rsp_ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic accept(input logic [1:0] op,
                        input logic [1:0] addr,
                        input logic [7:0] data);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_data_i  = data;
    vecs++;
    if (req_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL accept_ready: got %b want 1", req_ready_o);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_data_i  = 8'h00;
  endtask

  task automatic handshake(input string nm);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    vecs++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL %s_after_hs: got valid=%b ready=%b want 0 1",
               nm, rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    logic [3:0] we_exp;
    we_exp = 4'b0001 << addr;
    accept(2'd0, addr, data);
    vecs++;
    if (cell_we_o !== we_exp || cell_data_o !== data ||
        rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errs++;
      $display("FAIL write_pulse: got we=%b d=%h v=%b r=%b want %b %h 0 0",
               cell_we_o, cell_data_o, rsp_valid_o, req_ready_o,
               we_exp, data);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (cell_we_o !== 4'b0 || cell_data_o !== 8'h00 ||
        rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1 ||
        rsp_idx_o !== addr || rsp_data_o !== 8'h00) begin
      errs++;
      $display("FAIL write_rsp: got we=%b d=%h v=%b hit=%b idx=%0d data=%h want 0 00 1 1 %0d 00",
               cell_we_o, cell_data_o, rsp_valid_o, rsp_hit_o,
               rsp_idx_o, rsp_data_o, addr);
    end
    handshake("write");
  endtask

  task automatic do_search(input logic [7:0] key,
                           input logic       hit,
                           input logic [1:0] idx);
    accept(2'd1, 2'd0, key);
    vecs++;
    if (cell_se_o !== 1'b1 || cell_search_o !== key ||
        cell_we_o !== 4'b0) begin
      errs++;
      $display("FAIL search_pulse: got se=%b key=%h we=%b want 1 %h 0000",
               cell_se_o, cell_search_o, cell_we_o, key);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (cell_se_o !== 1'b0 || cell_search_o !== 8'h00 ||
        rsp_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL search_wait: got se=%b key=%h v=%b want 0 00 0",
               cell_se_o, cell_search_o, rsp_valid_o);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (rsp_valid_o !== 1'b1 || rsp_hit_o !== hit ||
        rsp_idx_o !== idx || rsp_data_o !== 8'h00) begin
      errs++;
      $display("FAIL search_rsp key=%h: got v=%b hit=%b idx=%0d data=%h want 1 %b %0d 00",
               key, rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_data_o,
               hit, idx);
    end
    handshake("search");
  endtask

  task automatic do_inval(input logic [1:0] addr);
    accept(2'd3, addr, 8'h00);
    vecs++;
    if (rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1 ||
        rsp_idx_o !== addr || cell_we_o !== 4'b0) begin
      errs++;
      $display("FAIL inval_rsp: got v=%b hit=%b idx=%0d we=%b want 1 1 %0d 0000",
               rsp_valid_o, rsp_hit_o, rsp_idx_o, cell_we_o, addr);
    end
    handshake("inval");
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (cell_we_o !== 4'b0 || cell_se_o !== 1'b0 ||
        cell_data_o !== 8'h00 || cell_search_o !== 8'h00 ||
        rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 ||
        rsp_hit_o !== 1'b0 || rsp_idx_o !== 2'd0 ||
        rsp_data_o !== 8'h00) begin
      errs++;
      $display("FAIL reset_outputs: got we=%b se=%b d=%h k=%h v=%b r=%b hit=%b idx=%0d data=%h want all 0",
               cell_we_o, cell_se_o, cell_data_o, cell_search_o,
               rsp_valid_o, req_ready_o, rsp_hit_o, rsp_idx_o,
               rsp_data_o);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 ||
        cell_we_o !== 4'b0 || cell_se_o !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: got r=%b v=%b we=%b se=%b want 1 0 0000 0",
               req_ready_o, rsp_valid_o, cell_we_o, cell_se_o);
    end
  endtask

  task automatic test_write_search;
    do_write(2'd2, 8'hA5);
    do_search(8'hA5, 1'b1, 2'd2);
    do_search(8'h5A, 1'b0, 2'd0);
  endtask

  task automatic test_multi_match;
    do_write(2'd1, 8'h3C);
    do_write(2'd3, 8'h3C);
    do_search(8'h3C, 1'b1, 2'd1);
    do_inval(2'd1);
    do_search(8'h3C, 1'b1, 2'd3);
    do_write(2'd2, 8'h77);
    do_search(8'h77, 1'b1, 2'd2);
    do_search(8'hA5, 1'b0, 2'd0);
  endtask

  task automatic test_read_backpressure;
    int hs0;
    hs0 = hs_cnt;
    accept(2'd2, 2'd3, 8'h00);
    vecs++;
    if (rsp_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL read_early: got v=%b want 0", rsp_valid_o);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1 ||
          rsp_idx_o !== 2'd3 || rsp_data_o !== 8'h3C ||
          req_ready_o !== 1'b0 || cell_we_o !== 4'b0 ||
          cell_se_o !== 1'b0) begin
        errs++;
        $display("FAIL read_hold[%0d]: got v=%b hit=%b idx=%0d data=%h r=%b we=%b se=%b want 1 1 3 3c 0 0000 0",
                 i, rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_data_o,
                 req_ready_o, cell_we_o, cell_se_o);
      end
      @(posedge clk);
      #1;
    end
    handshake("read");
    vecs++;
    if (hs_cnt - hs0 !== 1) begin
      errs++;
      $display("FAIL read_hs_count: got %0d want 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_mid_search;
    accept(2'd1, 2'd0, 8'hA5);
    vecs++;
    if (cell_se_o !== 1'b1) begin
      errs++;
      $display("FAIL midrst_se_before: got %b want 1", cell_se_o);
    end
    #1;
    reset = 1'b0;
    #1;
    vecs++;
    if (cell_se_o !== 1'b0 || cell_search_o !== 8'h00 ||
        rsp_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL midrst_cut: got se=%b k=%h v=%b want 0 00 0",
               cell_se_o, cell_search_o, rsp_valid_o);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        errs++;
        $display("FAIL midrst_idle[%0d]: got v=%b r=%b want 0 1",
                 i, rsp_valid_o, req_ready_o);
      end
    end
    do_search(8'hA5, 1'b0, 2'd0);
    do_search(8'h3C, 1'b0, 2'd0);
    do_search(8'h00, 1'b0, 2'd0);
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    hs_cnt      = 0;
    reset       = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = 2'd0;
    req_addr_i  = 2'd0;
    req_data_i  = 8'h00;
    rsp_ready_i = 1'b0;
    test_reset();
    test_write_search();
    test_multi_match();
    test_read_backpressure();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
